// File: rtl/risc_pkg.sv
// Shared ISA definitions for the 8-bit RISC core: opcodes and instruction-cycle phases.
package risc_pkg;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    // Opcodes that read an operand from memory and write the accumulator.
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Free-running 3-bit instruction-phase counter; wraps 7 -> 0, holds when enable is low.
module phase_counter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    output logic [2:0] phase_o
);

    logic [2:0] cnt_q, cnt_d;

    always_comb cnt_d = en_i ? cnt_q + 3'd1 : cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= 3'd0;
        else       cnt_q <= cnt_d;
    end

    assign phase_o = cnt_q;

endmodule

// File: rtl/risc_controller.sv
// Instruction sequencer: steps the 8-phase cycle and decodes (phase, opcode, zero) into
// datapath strobes; a HLT in OP_ADDR freezes the sequencer until reset.
module risc_controller
    import risc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       wr,
    output logic       data_e,
    output logic [2:0] phase
);

    logic       halted_q, halted_d;
    logic [2:0] phase_q;
    logic       aluop;

    // State register: halt flag; the phase itself lives in the counter.
    always_ff @(posedge clk) begin
        if (rst) halted_q <= 1'b0;
        else     halted_q <= halted_d;
    end

    // Next state: the counter is gated with the next halt value so the edge that
    // latches halted also leaves the phase parked in OP_ADDR.
    always_comb begin
        halted_d = halted_q;
        if (phase_e'(phase_q) == OP_ADDR && opcode == HLT) halted_d = 1'b1;
    end

    phase_counter u_phase (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (~halted_d),
        .phase_o (phase_q)
    );

    assign phase = phase_q;
    assign aluop = is_aluop(opcode);

    // Output decode.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_e'(phase_q))
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == HLT);
                end
                OP_FETCH: begin
                    rd = aluop;
                end
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opcode == SKZ) && zero;
                    ld_pc  = (opcode == JMP);
                    data_e = (opcode == STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    inc_pc = (opcode == JMP);
                    ld_pc  = (opcode == JMP);
                    wr     = (opcode == STO);
                    data_e = (opcode == STO);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_controller.sv
// Bench for risc_controller: directed per-phase tables plus randomized traffic checked
// every cycle against a behavioural model of the instruction cycle.
module tb_risc_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd2;
    logic       zero = 1'b0;
    logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    logic [2:0] phase;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    int m_ph = 0;
    bit m_h = 1'b0;

    always #5 clk = ~clk;

    risc_controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .halt   (halt),
        .inc_pc (inc_pc),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .wr     (wr),
        .data_e (data_e),
        .phase  (phase)
    );

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Expected strobes {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e} from the ISA rules.
    function automatic logic [8:0] exp_out(int ph, bit h, logic [2:0] op, logic z);
        bit alu, s, r, li, hl, inc, la, lp, w, de;
        alu = (op >= 3'd2) && (op <= 3'd5);
        if (h) return 9'b000100000;
        s   = (ph <= 3);
        r   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        li  = (ph == 2 || ph == 3);
        hl  = (ph == 4 && op == 3'd0);
        inc = (ph == 4) || (ph == 6 && op == 3'd1 && z) || (ph == 7 && op == 3'd7);
        la  = (ph == 7 && alu);
        lp  = (ph >= 6 && op == 3'd7);
        w   = (ph == 7 && op == 3'd6);
        de  = (ph >= 6 && op == 3'd6);
        return {s, r, li, hl, inc, la, lp, w, de};
    endfunction

    // Behavioural model of sequencing: advance a phase per clock unless halted.
    always @(posedge clk) begin
        if (rst) begin
            m_ph <= 0;
            m_h  <= 1'b0;
        end else if (!m_h) begin
            if (m_ph == 4 && opcode == 3'd0) m_h <= 1'b1;
            else                             m_ph <= (m_ph + 1) % 8;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_phase", {13'd0, phase}, m_ph[15:0]);
            chk("model_strobes", {7'd0, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e},
                {7'd0, exp_out(m_ph, m_h, opcode, zero)});
        end
    end

    // Runs one full instruction starting in phase 0 right after a clock edge; zero is
    // inverted during OP_FETCH to show it is ignored there.
    task automatic run_instr(input logic [2:0] op, input logic z,
                             input logic [7:0] t_rd, input logic [7:0] t_inc,
                             input logic [7:0] t_ldac, input logic [7:0] t_ldpc,
                             input logic [7:0] t_wr, input logic [7:0] t_de);
        logic [7:0] t_sel, t_ldir;
        t_sel  = 8'b0000_1111;
        t_ldir = 8'b0000_1100;
        for (int i = 0; i < 8; i++) begin
            #1;
            rst    = 1'b0;
            opcode = op;
            zero   = (i == 5) ? ~z : z;
            #1;
            chk("phase", {13'd0, phase}, i[15:0]);
            chk("sel",    {15'd0, sel},    {15'd0, t_sel[i]});
            chk("ld_ir",  {15'd0, ld_ir},  {15'd0, t_ldir[i]});
            chk("rd",     {15'd0, rd},     {15'd0, t_rd[i]});
            chk("inc_pc", {15'd0, inc_pc}, {15'd0, t_inc[i]});
            chk("ld_ac",  {15'd0, ld_ac},  {15'd0, t_ldac[i]});
            chk("ld_pc",  {15'd0, ld_pc},  {15'd0, t_ldpc[i]});
            chk("wr",     {15'd0, wr},     {15'd0, t_wr[i]});
            chk("data_e", {15'd0, data_e}, {15'd0, t_de[i]});
            chk("halt",   {15'd0, halt},   16'd0);
            @(posedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        opcode = 3'd2;
        @(posedge clk);
        #1 chk_en = 1'b1;
        #1;
        chk("rst_phase", {13'd0, phase}, 16'd0);
        chk("rst_strobes", {7'd0, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e},
            16'b0000000_100000000);
        repeat (2) @(posedge clk);

        // ALU ops
        for (int k = 2; k <= 5; k++)
            run_instr(k[2:0], 1'b0, 8'b1110_1110, 8'b0001_0000, 8'b1000_0000,
                      8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
        // STO
        run_instr(3'd6, 1'b0, 8'b0000_1110, 8'b0001_0000, 8'b0000_0000,
                  8'b0000_0000, 8'b1000_0000, 8'b1100_0000);
        // SKZ taken / not taken
        run_instr(3'd1, 1'b1, 8'b0000_1110, 8'b0101_0000, 8'b0000_0000,
                  8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
        run_instr(3'd1, 1'b0, 8'b0000_1110, 8'b0001_0000, 8'b0000_0000,
                  8'b0000_0000, 8'b0000_0000, 8'b0000_0000);
        // JMP
        run_instr(3'd7, 1'b0, 8'b0000_1110, 8'b1001_0000, 8'b0000_0000,
                  8'b1100_0000, 8'b0000_0000, 8'b0000_0000);

        // HLT: halt combinational in phase 4, then frozen
        for (int i = 0; i < 4; i++) begin
            #1 opcode = 3'd0;
            @(posedge clk);
        end
        #2;
        chk("hlt_phase4", {13'd0, phase}, 16'd4);
        chk("hlt_halt_p4", {15'd0, halt}, 16'd1);
        chk("hlt_inc_p4", {15'd0, inc_pc}, 16'd1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            chk("halted_phase", {13'd0, phase}, 16'd4);
            chk("halted_strobes", {7'd0, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e},
                16'b0000000_000100000);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("unhalt_phase", {13'd0, phase}, 16'd0);
        chk("unhalt_halt", {15'd0, halt}, 16'd0);

        // rst together with HLT in phase 4: no halt latched
        for (int i = 0; i < 4; i++) @(posedge clk);
        #2;
        chk("rsthlt_p4", {13'd0, phase}, 16'd4);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #2;
        chk("rsthlt_phase", {13'd0, phase}, 16'd1);
        chk("rsthlt_halt", {15'd0, halt}, 16'd0);

        // Randomized traffic; the model compare runs every cycle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            opcode = 3'($urandom_range(0, 7));
            zero   = 1'($urandom_range(0, 1));
            rst    = ($urandom_range(0, 31) == 0);
        end
        @(negedge clk);
        #1 chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/risc_controller.md
# risc_controller

Instruction sequencer for the 8-bit RISC core. It steps a fixed 8-phase instruction cycle and decodes the current 3-bit opcode (from the instruction register) into the control strobes for memory, instruction register, program counter and accumulator. The same opcode drives the ALU directly. The controller consumes the ALU's accumulator-zero flag to resolve SKZ. It sits between the instruction register and the datapath.

## Interface
- No parameters; the phase count (8) and opcode width (3) are fixed by the ISA.
- `clk`  in  1  sole clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  3  current instruction opcode from the instruction register
- `zero`  in  1  accumulator-is-zero flag from the ALU
- `sel`  out  1  address mux select: 1 = PC, 0 = instruction operand
- `rd`  out  1  memory read enable
- `ld_ir`  out  1  load instruction register
- `halt`  out  1  processor halted
- `inc_pc`  out  1  increment program counter
- `ld_ac`  out  1  load accumulator from ALU output
- `ld_pc`  out  1  load program counter from operand
- `wr`  out  1  memory write strobe
- `data_e`  out  1  drive accumulator onto data bus
- `phase`  out  3  current phase, for debug and the bench

## Operation
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. Define ALUOP = ADD|AND|XOR|LDA.
- Phases: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7). Phase 7 wraps to 0.
- Outputs are combinational decodes of (phase, opcode, zero). Every strobe not listed for a phase is 0.
  - Phase 0: sel.
  - Phase 1: sel, rd.
  - Phase 2: sel, rd, ld_ir.
  - Phase 3: sel, rd, ld_ir.
  - Phase 4: inc_pc. halt = (opcode==HLT).
  - Phase 5: rd = ALUOP.
  - Phase 6: rd = ALUOP. inc_pc = (SKZ & zero). ld_pc = JMP. data_e = STO.
  - Phase 7: rd = ALUOP. ld_ac = ALUOP. inc_pc = JMP. ld_pc = JMP. wr = STO. data_e = STO.
- Halt handling:
  - In phase 4 with opcode HLT, a `halted` flag register sets on the next edge.
  - While `halted`=1: phase freezes at 4, halt=1, and every other strobe is forced to 0. This includes inc_pc, so the PC does not advance again.
  - Only `rst` clears `halted`.
- `zero` is sampled only in phase 6. It has no effect in any other phase.
- Opcode changes outside phases 2–3 are not checked. The decode always uses the current value.

## Timing
- Reset (sync): phase=0 and halted=0 on the first edge with rst=1. While rst is held, the outputs are the phase-0 decode: sel=1, all others 0.
- One phase per clock. A full instruction takes 8 cycles. The first INST_ADDR is the first cycle after rst deasserts.
- The HLT opcode's halt output appears combinationally in phase 4. It then stays asserted from the next cycle until reset.
- Reset mid-instruction (any phase, halted or not) returns to phase 0 on the next edge. No strobes from the aborted instruction persist.
- Simultaneous rst and HLT in phase 4: reset wins, so halted stays 0.

## Structure
- Shared package `risc_pkg`:
  - opcode localparams HLT…JMP, shared with the ALU and the instruction register;
  - phase enum/localparams INST_ADDR…STORE.
- One sub-module, `phase_counter`: 3-bit counter with sync active-high reset and an enable that wraps 7→0. The controller drives its enable with `~halted`.
- Output decode is a single combinational case on phase inside `risc_controller`.

## Test plan
- **Reset:** hold rst 3 cycles, release with opcode=ADD → phase sequence 0,1,…,7,0. Check sel=1 in phases 0–3 only. Check ld_ir=1 in phases 2–3.
- **ALU op:** opcode=ADD (then AND, XOR, LDA) → rd=1 in phases 5–7, ld_ac=1 only in phase 7, wr=data_e=ld_pc=0 throughout.
- **STO:** opcode=STO → data_e=1 in phases 6–7, wr=1 only in phase 7, rd=0 in phases 5–7.
- **SKZ:** opcode=SKZ with zero=1 → inc_pc=1 in phases 4 and 6. With zero=0 → inc_pc only in phase 4. Toggle zero in phase 5 to confirm it is ignored there.
- **JMP:** opcode=JMP → ld_pc=1 in phases 6–7, inc_pc=1 in phases 4 and 7.
- **HLT:** opcode=HLT → halt=1 in phase 4. Phase stays 4 for 20 further cycles with halt=1 and all other strobes 0. Then pulse rst 1 cycle → phase=0, halt=0. Also assert rst during phase 4 with HLT → no halt latched.
